and_unit_arbiter: RTL and testbench

- Shares one registered bitwise-AND unit (the `mem <= a & b` datapath) among `N_REQ` requesters.
- Round-robin grant; latches the winner's operands and computes `a & b` into a result register.
- Holds the result, tagged with the winner's index, until the downstream consumer accepts it.
- Sits between the requesting front-end blocks and the single shared logic-unit result path.

---
 rtl/and_arb_pkg.sv | 15 +
 rtl/and_unit_arbiter_if.sv | 31 +++
 rtl/and_unit_arbiter_rr_pick.sv | 34 +++
 rtl/and_unit_arbiter.sv | 94 +++++++++
 tb/tb_and_unit_arbiter.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/and_arb_pkg.sv
// Shared definitions for the round-robin arbiter in front of the shared AND unit.
// Holds the default geometry, the result-counter width and the FSM state encoding.
package and_arb_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_W     = 8;
  localparam int DEF_IDW   = 2;
  localparam int OPCNT_W   = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/and_unit_arbiter_if.sv
// Request/operand bundle from the front-end blocks plus the shared result path.
// The arbiter is the slave side; requesters and the consumer form the master side.
interface and_unit_arbiter_if
  import and_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int W     = DEF_W,
  parameter int IDW   = DEF_IDW
);

  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] a_in;
  logic [N_REQ*W-1:0] b_in;
  logic [N_REQ-1:0]   gnt;
  logic               res_valid;
  logic [W-1:0]       res_data;
  logic [IDW-1:0]     res_id;
  logic               res_ready;
  logic [OPCNT_W-1:0] op_count;

  modport master (
    output req, a_in, b_in, res_ready,
    input  gnt, res_valid, res_data, res_id, op_count
  );

  modport slave (
    input  req, a_in, b_in, res_ready,
    output gnt, res_valid, res_data, res_id, op_count
  );

endinterface

// File: rtl/and_unit_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping from N_REQ-1 back to 0. Nothing is granted while en_i is low.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDW-1:0]   ptr_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDW-1:0]   idx_o,
  output logic             any_o
);

  always_comb begin
    logic [IDW-1:0] j;
    logic           found;
    // NOTE: every output gets a default before the search loop, so no path leaves one unassigned and no latch is inferred.
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = IDW'((int'(ptr_i) + k) % N_REQ);
      if (en_i && !found && req_i[j]) begin
        found    = 1'b1;
        idx_o    = j;
        gnt_o[j] = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/and_unit_arbiter.sv
// Shares one registered bitwise-AND unit among N_REQ requesters with round-robin
// grant; the tagged result is held until the consumer accepts it.
module and_unit_arbiter
  import and_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int W     = DEF_W,
  parameter int IDW   = DEF_IDW
) (
  input logic              clk,
  input logic              reset,
  and_unit_arbiter_if.slave bus
);

  state_t             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic               res_valid_q, res_valid_d;
  logic [W-1:0]       res_data_q, res_data_d;
  logic [IDW-1:0]     res_id_q, res_id_d;
  logic [OPCNT_W-1:0] op_count_q, op_count_d;

  logic               can_issue;
  logic               pick_en;
  logic [N_REQ-1:0]   gnt;
  logic [IDW-1:0]     win_idx;
  logic               win_any;
  logic [W-1:0]       a_sel;
  logic [W-1:0]       b_sel;

  // Accepting a held result frees the register on the same edge: one result per cycle.
  assign can_issue = (state_q == ST_IDLE) || bus.res_ready;
  assign pick_en   = can_issue && !reset;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_pick (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .en_i  (pick_en),
    .gnt_o (gnt),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  assign a_sel = bus.a_in[int'(win_idx)*W +: W];
  assign b_sel = bus.b_in[int'(win_idx)*W +: W];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    op_count_d  = op_count_q;
    if (win_any) begin
      res_data_d  = a_sel & b_sel;
      res_id_d    = win_idx;
      res_valid_d = 1'b1;
      state_d     = ST_HOLD;
      ptr_d       = (win_idx == IDW'(N_REQ - 1)) ? '0 : win_idx + IDW'(1);
      op_count_d  = op_count_q + OPCNT_W'(1);
    end else if (bus.res_ready && res_valid_q) begin
      res_valid_d = 1'b0;
      state_d     = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      op_count_q  <= op_count_d;
    end
  end

  assign bus.gnt       = gnt;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;
  assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_and_unit_arbiter.sv
// Directed bench for and_unit_arbiter: each grant pushes its expected tagged
// result to a scoreboard that is popped when the result register loads.
module tb_and_unit_arbiter;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] id;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  exp_t        sb[$];
  logic        m_valid;
  logic [1:0]  m_ptr;
  logic [15:0] m_cnt;
  logic [7:0]  m_data;
  logic [1:0]  m_id;

  and_unit_arbiter_if #(.N_REQ(4), .W(8), .IDW(2)) bus ();

  and_unit_arbiter #(.N_REQ(4), .W(8), .IDW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input logic [1:0] p);
    for (int k = 0; k < 4; k++)
      if (r[(int'(p) + k) % 4]) return (int'(p) + k) % 4;
    return -1;
  endfunction

  task automatic randomize_ops();
    bus.a_in = $urandom();
    bus.b_in = $urandom();
  endtask

  // Entered just after a rising edge with this cycle's inputs driven; returns
  // just after the next rising edge. exp_g >= 0 adds a directed grant check.
  task automatic run_cycle(input string tag, input int exp_g = -1);
    logic [3:0] eg;
    logic       can;
    int         w;
    exp_t       e;
    #2;
    can = !m_valid || bus.res_ready;
    w   = -1;
    eg  = '0;
    if (!reset && can) w = pick(bus.req, m_ptr);
    if (w >= 0) eg[w] = 1'b1;
    check({tag, "_gnt_model"}, 32'(bus.gnt), 32'(eg));
    if (exp_g >= 0) check({tag, "_gnt"}, 32'(bus.gnt), 32'(exp_g));
    if (w >= 0) sb.push_back('{data: bus.a_in[w*8 +: 8] & bus.b_in[w*8 +: 8], id: 2'(w)});
    @(posedge clk);
    #1;
    if (reset) begin
      m_valid = 1'b0;
      m_ptr   = '0;
      m_cnt   = '0;
      m_data  = '0;
      m_id    = '0;
      sb.delete();
    end else if (w >= 0) begin
      m_valid = 1'b1;
      m_ptr   = 2'((w + 1) % 4);
      m_cnt   = m_cnt + 16'd1;
      if (sb.size() > 0) begin
        e      = sb.pop_front();
        m_data = e.data;
        m_id   = e.id;
      end
    end else if (bus.res_ready) begin
      m_valid = 1'b0;
    end
    check({tag, "_valid"}, 32'(bus.res_valid), 32'(m_valid));
    check({tag, "_data"},  32'(bus.res_data),  32'(m_data));
    check({tag, "_id"},    32'(bus.res_id),    32'(m_id));
    check({tag, "_cnt"},   32'(bus.op_count),  32'(m_cnt));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_valid  = 1'b0;
    m_ptr    = '0;
    m_cnt    = '0;
    m_data   = '0;
    m_id     = '0;

    // Reset held two cycles with all requests high: no grants, outputs cleared.
    reset         = 1'b1;
    bus.req       = 4'b1111;
    bus.res_ready = 1'b0;
    randomize_ops();
    run_cycle("rst0", 0);
    run_cycle("rst1", 0);
    check("rst_valid", 32'(bus.res_valid), 32'd0);
    check("rst_data",  32'(bus.res_data),  32'd0);
    check("rst_id",    32'(bus.res_id),    32'd0);
    check("rst_cnt",   32'(bus.op_count),  32'd0);
    reset         = 1'b0;
    bus.res_ready = 1'b1;
    run_cycle("first", 4'b0001);

    // Single request from requester 2.
    reset   = 1'b1;
    bus.req = 4'b0000;
    run_cycle("rst2", 0);
    reset   = 1'b0;
    bus.req = 4'b0100;
    randomize_ops();
    bus.a_in[2*8 +: 8] = 8'hF0;
    bus.b_in[2*8 +: 8] = 8'h3C;
    run_cycle("single", 4'b0100);
    check("single_valid", 32'(bus.res_valid), 32'd1);
    check("single_data",  32'(bus.res_data),  32'h30);
    check("single_id",    32'(bus.res_id),    32'd2);
    check("single_cnt",   32'(bus.op_count),  32'd1);
    bus.req = 4'b0000;
    run_cycle("drain0", 0);
    check("drain0_valid", 32'(bus.res_valid), 32'd0);

    // Round robin with everyone requesting and the consumer always ready.
    reset = 1'b1;
    run_cycle("rst3", 0);
    reset   = 1'b0;
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      randomize_ops();
      run_cycle("rr", 1 << (i % 4));
      check("rr_valid", 32'(bus.res_valid), 32'd1);
    end

    // Back-pressure: pointer now at 1, result held; requester 1 must wait.
    bus.req       = 4'b0010;
    bus.res_ready = 1'b0;
    randomize_ops();
    for (int i = 0; i < 3; i++) run_cycle("bp", 0);
    bus.res_ready = 1'b1;
    run_cycle("bp_release", 4'b0010);
    check("bp_release_id", 32'(bus.res_id), 32'd1);
    bus.req = 4'b0000;
    run_cycle("drain1", 0);

    // Wrap and skip: steer ptr to 3, then requesters 0 and 1.
    reset = 1'b1;
    run_cycle("rst4", 0);
    reset   = 1'b0;
    bus.req = 4'b0100;
    run_cycle("to_ptr3", 4'b0100);
    bus.req = 4'b0000;
    run_cycle("drain2", 0);
    bus.req = 4'b0011;
    randomize_ops();
    run_cycle("wrap0", 4'b0001);
    check("wrap0_id", 32'(bus.res_id), 32'd0);
    bus.req = 4'b0010;
    run_cycle("wrap1", 4'b0010);
    check("wrap1_id",    32'(bus.res_id),    32'd1);
    check("wrap1_valid", 32'(bus.res_valid), 32'd1);

    // Reset while a result from requester 1 is held: it is discarded.
    bus.res_ready = 1'b0;
    bus.req       = 4'b1111;
    reset         = 1'b1;
    run_cycle("midrst", 0);
    check("midrst_valid", 32'(bus.res_valid), 32'd0);
    reset         = 1'b0;
    bus.res_ready = 1'b1;
    run_cycle("post_rst", 4'b0001);
    check("post_rst_id", 32'(bus.res_id), 32'd0);

    // Counter wrap: 65535 grants from reset, then one more.
    reset = 1'b1;
    run_cycle("rst5", 0);
    reset   = 1'b0;
    bus.req = 4'b1111;
    for (int i = 0; i < 65535; i++) run_cycle("preload");
    check("cnt_max", 32'(bus.op_count), 32'hFFFF);
    run_cycle("cnt_wrap");
    check("cnt_wrap_zero", 32'(bus.op_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
